rom_read_arbiter: RTL and testbench

//  - Shares the single-port 8x4 registered-output ROM between two requesters.
//  - Each requester issues reads with a valid/ready request handshake and gets
//    its data back with a valid/ready response handshake.
//  - Sequences the ROM's en/addr and samples its output one cycle after en,
//    the only cycle in which that output is defined.
//  - Sits between the ROM instance and the client logic that reads it.

---
 rtl/rom_read_arbiter.sv | 93 +++++++++
 tb/tb_rom_read_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/rom_read_arbiter.sv
// Two-requester arbiter in front of a single-port registered-output ROM.
// Optional build macro: ROM_ARB_FIXED_PRIO_EN (requester 0 always wins contests).
module rom_read_arbiter #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  input  logic [2*ADDR_W-1:0] req_addr,
  output logic [1:0]          req_ready,
  output logic [1:0]          rsp_valid,
  output logic [DATA_W-1:0]   rsp_data,
  input  logic [1:0]          rsp_ready,
  output logic                busy,
  output logic                rom_en,
  output logic [ADDR_W-1:0]   rom_addr,
  input  logic [DATA_W-1:0]   rom_val
);

  typedef enum logic [1:0] {IDLE, READ, CAPT, RESP} state_t;

  state_t              state;
  state_t              state_next;
  logic [ADDR_W-1:0]   addr_q;
  logic                owner;
  logic                last_grant;
  logic [1:0]          grant;
  logic                accept;

  // Grant is only ever offered in IDLE, and only to a requester that is asking.
  always_comb begin
    grant = 2'b00;
    if (state == IDLE) begin
      case (req_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11: begin
`ifdef ROM_ARB_FIXED_PRIO_EN
          grant = 2'b01;
`else
          grant = last_grant ? 2'b01 : 2'b10;
`endif
        end
        default: grant = 2'b00;
      endcase
    end
  end

  assign req_ready = grant;
  assign accept    = |grant;
  assign busy      = (state != IDLE);
  assign rom_en    = (state == READ);
  assign rom_addr  = addr_q;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = READ;
      READ:    state_next = CAPT;
      CAPT:    state_next = RESP;
      RESP:    if (rsp_ready[owner]) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // rom_val is only defined the cycle after en, which is exactly CAPT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      addr_q     <= '0;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      rsp_valid  <= 2'b00;
      rsp_data   <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q     <= grant[1] ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
        owner      <= grant[1];
        last_grant <= grant[1];
      end
      if (state == CAPT) begin
        rsp_data  <= rom_val;
        rsp_valid <= owner ? 2'b10 : 2'b01;
      end
      if (state == RESP && rsp_ready[owner]) begin
        rsp_valid <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_rom_read_arbiter.sv
// Self-checking bench for rom_read_arbiter: transaction-level reference model,
// registered ROM model that drives garbage whenever its output is undefined.
module tb_rom_read_arbiter;

  localparam int ADDR_W = 3;
  localparam int DATA_W = 4;

  logic                clk;
  logic                rst;
  logic [1:0]          req_valid;
  logic [2*ADDR_W-1:0] req_addr;
  logic [1:0]          req_ready;
  logic [1:0]          rsp_valid;
  logic [DATA_W-1:0]   rsp_data;
  logic [1:0]          rsp_ready;
  logic                busy;
  logic                rom_en;
  logic [ADDR_W-1:0]   rom_addr;
  logic [DATA_W-1:0]   rom_val;

  int assertCount = 0;
  int failCount   = 0;

  logic [DATA_W-1:0] romTable [8] = '{4'd10, 4'd3, 4'd12, 4'd6, 4'd1, 4'd15, 4'd9, 4'd8};

  // Reference model state: one transaction described by owner, address and age
  bit          mBusy;
  int          mAge;
  bit          mOwner;
  logic [2:0]  mAddr;
  bit          mLast;

  rom_read_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rsp_ready(rsp_ready), .busy(busy), .rom_en(rom_en), .rom_addr(rom_addr),
    .rom_val(rom_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM output is valid only the cycle after en; otherwise it is noise.
  always @(posedge clk) begin
    if (rom_en) rom_val <= romTable[rom_addr];
    else        rom_val <= 4'($urandom);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic logic [1:0] modelGrant(input logic [1:0] v);
    if (mBusy)        return 2'b00;
    if (v == 2'b01)   return 2'b01;
    if (v == 2'b10)   return 2'b10;
    if (v == 2'b11) begin
`ifdef ROM_ARB_FIXED_PRIO_EN
      return 2'b01;
`else
      return mLast ? 2'b01 : 2'b10;
`endif
    end
    return 2'b00;
  endfunction

  task automatic modelReset();
    mBusy  = 0;
    mAge   = 0;
    mOwner = 0;
    mAddr  = '0;
    mLast  = 1;
  endtask

  // Drive one cycle of inputs, check every output against the model, then
  // advance the model to what the coming rising edge should produce.
  task automatic applyStimulus(input logic [1:0] v, input logic [2:0] a0,
                               input logic [2:0] a1, input logic [1:0] rr);
    logic [1:0] expGrant;
    logic [1:0] expRsp;
    @(negedge clk);
    req_valid = v;
    req_addr  = {a1, a0};
    rsp_ready = rr;
    #1;
    expGrant = modelGrant(v);
    expRsp   = (mBusy && mAge >= 3) ? (mOwner ? 2'b10 : 2'b01) : 2'b00;
    checkOutput("req_ready", 32'(req_ready), 32'(expGrant));
    checkOutput("busy", 32'(busy), 32'(mBusy));
    checkOutput("rom_en", 32'(rom_en), 32'(mBusy && mAge == 1));
    if (mBusy && mAge == 1) checkOutput("rom_addr", 32'(rom_addr), 32'(mAddr));
    checkOutput("rsp_valid", 32'(rsp_valid), 32'(expRsp));
    if (expRsp != 2'b00) checkOutput("rsp_data", 32'(rsp_data), 32'(romTable[mAddr]));
    if (!mBusy) begin
      if (expGrant != 2'b00) begin
        mBusy  = 1;
        mAge   = 1;
        mOwner = expGrant[1];
        mAddr  = expGrant[1] ? a1 : a0;
        mLast  = expGrant[1];
      end
    end else if (mAge >= 3 && rr[mOwner]) begin
      mBusy = 0;
    end else begin
      mAge++;
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 2'b00;
    rsp_ready = 2'b00;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_rom_en", 32'(rom_en), 32'd0);
    checkOutput("rst_rom_addr", 32'(rom_addr), 32'd0);
    checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    checkOutput("rst_rsp_data", 32'(rsp_data), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 2'b00;
    req_addr  = '0;
    rsp_ready = 2'b00;
    modelReset();
    repeat (2) @(posedge clk);
    doReset();

    // Single read of address 0 by requester 0
    applyStimulus(2'b01, 3'd0, 3'd0, 2'b01);
    repeat (5) applyStimulus(2'b00, 3'd0, 3'd0, 2'b01);

    // Contention with both requesters held valid
    repeat (20) applyStimulus(2'b11, 3'd5, 3'd7, 2'b11);
    repeat (4) applyStimulus(2'b00, 3'd0, 3'd0, 2'b11);

    // Backpressure during the response phase
    applyStimulus(2'b10, 3'd1, 3'd2, 2'b00);
    repeat (8) applyStimulus(2'b11, 3'd3, 3'd4, 2'b00);
    repeat (3) applyStimulus(2'b00, 3'd0, 3'd0, 2'b11);

    // Response owned by requester 1; ready from the wrong requester is ignored
    applyStimulus(2'b10, 3'd0, 3'd6, 2'b01);
    repeat (6) applyStimulus(2'b00, 3'd0, 3'd0, 2'b01);
    repeat (2) applyStimulus(2'b00, 3'd0, 3'd0, 2'b10);

    // Requester 1 drops out, requester 0 keeps asking
    repeat (8) applyStimulus(2'b01, 3'd7, 3'd2, 2'b11);
    repeat (8) applyStimulus(2'b10, 3'd7, 3'd2, 2'b11);

    // Reset asserted mid-READ aborts the transaction with no response
    applyStimulus(2'b01, 3'd5, 3'd0, 2'b11);
    doReset();
    repeat (6) applyStimulus(2'b00, 3'd0, 3'd0, 2'b11);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      applyStimulus(2'($urandom), 3'($urandom), 3'($urandom),
                    ($urandom_range(0, 3) == 0) ? 2'b00 : 2'($urandom));
    end
    repeat (8) applyStimulus(2'b00, 3'd0, 3'd0, 2'b11);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
